// File: rtl/pin_entry_collector.sv
// pin_entry_collector
//   Collects keypad strobes into a 4-digit PIN buffer and emits a one-cycle
//   pinPac_t packet {status, digit1, digit2, digit3, digit4} on a valid enter.
//   Supports backspace, clear, and an inactivity timeout. Empty slots read as 4'hF.
//
//   Ports
//     clk            system clock
//     rst            asynchronous, active-high reset
//     enable         collector active; low flushes the buffer and ignores keys
//     key_valid      one-cycle strobe qualifying key_code
//     key_code       0-9 digit, A backspace, B enter, C clear, D-F ignored
//     pin_out        registered packet; status=1 only during SEND
//     digit_count    digits currently buffered (0..4)
//     busy           high during SEND; keys are dropped while high
//     err_pulse      one-cycle pulse when enter is pressed with 1..3 digits
//     timeout_pulse  one-cycle pulse when inactivity flushes a non-empty buffer
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | buffer empty, timer held at 0
//   S_COLLECT | 1..4 digits buffered, inactivity timer running
//   S_SEND    | packet on pin_out for exactly this cycle, then flush to IDLE

module pin_entry_collector #(
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [16:0] pin_out,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        err_pulse,
    output logic        timeout_pulse
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    localparam logic [3:0]       K_BKSP     = 4'hA;
    localparam logic [3:0]       K_ENTER    = 4'hB;
    localparam logic [3:0]       K_CLEAR    = 4'hC;
    localparam logic [16:0]      PKT_IDLE   = {1'b0, 16'hFFFF};
    // Expiry is detected one count early so the flush lands on the edge where
    // the timer would have reached TIMEOUT_CYCLES; the counter never exceeds it.
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       dig_q [4];
    logic [3:0]       dig_d [4];
    logic [2:0]       count_q, count_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [16:0]      pin_out_q, pin_out_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;

    logic             is_digit;
    logic [1:0]       wr_idx;
    logic [1:0]       bk_idx;

    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        count_d   = count_q;
        timer_d   = '0;
        pin_out_d = PKT_IDLE;
        busy_d    = 1'b0;
        err_d     = 1'b0;
        tmo_d     = 1'b0;

        is_digit  = (key_code <= 4'd9);
        wr_idx    = count_q[1:0];
        bk_idx    = count_q[1:0] - 2'd1;

        case (state_q)
            S_SEND: begin
                // Keys and enable are not looked at here: the packet is already out.
                dig_d   = '{default: 4'hF};
                count_d = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                if (!enable) begin
                    dig_d   = '{default: 4'hF};
                    count_d = 3'd0;
                    state_d = S_IDLE;
                end else if (key_valid && is_digit) begin
                    // A fifth digit is dropped but still counts as activity.
                    if (count_q < 3'd4) begin
                        dig_d[wr_idx] = key_code;
                        count_d       = count_q + 3'd1;
                        state_d       = S_COLLECT;
                    end
                end else if (key_valid && key_code == K_BKSP && count_q != 3'd0) begin
                    dig_d[bk_idx] = 4'hF;
                    count_d       = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end else if (key_valid && key_code == K_CLEAR) begin
                    dig_d   = '{default: 4'hF};
                    count_d = 3'd0;
                    state_d = S_IDLE;
                end else if (key_valid && key_code == K_ENTER && count_q != 3'd0) begin
                    if (count_q == 3'd4) begin
                        state_d   = S_SEND;
                        pin_out_d = {1'b1, dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
                        busy_d    = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        dig_d   = '{default: 4'hF};
                        count_d = 3'd0;
                        state_d = S_IDLE;
                    end
                end else if (state_q == S_COLLECT) begin
                    // No qualifying key this cycle (ignored codes land here too).
                    if (timer_q >= TIMER_LAST) begin
                        tmo_d   = 1'b1;
                        dig_d   = '{default: 4'hF};
                        count_d = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dig_q     <= '{default: 4'hF};
            count_q   <= 3'd0;
            timer_q   <= '0;
            pin_out_q <= PKT_IDLE;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            pin_out_q <= pin_out_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign pin_out       = pin_out_q;
    assign digit_count   = count_q;
    assign busy          = busy_q;
    assign err_pulse     = err_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
module tb_pin_entry_collector;

    localparam int TO = 20;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [16:0] pin_out;
    logic [2:0]  digit_count;
    logic        busy;
    logic        err_pulse;
    logic        timeout_pulse;

    pin_entry_collector #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .pin_out       (pin_out),
        .digit_count   (digit_count),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] EV_PKT = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;
    localparam logic [1:0] EV_TMO = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [16:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_pkt(input logic [15:0] digits);
        exp_q.push_back({EV_PKT, 1'b1, digits});
    endtask

    task automatic push_ev(input logic [1:0] kind);
        exp_q.push_back({kind, 17'h0});
    endtask

    // Strobe one key for one cycle; returns on the negedge after it was sampled.
    task automatic key(input logic [3:0] code, input int exp_cnt);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        chk("digit_count", 32'(digit_count), 32'(exp_cnt));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: every event seen on the outputs must match the next expected one.
    ev_t obs_ev;
    ev_t exp_ev;
    always @(negedge clk) begin
        if (!rst && (pin_out[16] || err_pulse || timeout_pulse)) begin
            chk("exclusive", 32'(int'(pin_out[16]) + int'(err_pulse) + int'(timeout_pulse)), 32'd1);
            obs_ev.kind = pin_out[16] ? EV_PKT : (err_pulse ? EV_ERR : EV_TMO);
            obs_ev.data = pin_out[16] ? pin_out : 17'h0;
            if (pin_out[16]) chk("busy_with_pkt", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(obs_ev), 32'd0);
            end else begin
                exp_ev = exp_q.pop_front();
                chk("event", 32'(obs_ev), 32'(exp_ev));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        idle(3);
        chk("rst_pin_out", 32'(pin_out), 32'h0FFFF);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        chk("rst_tmo", 32'(timeout_pulse), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1,2,3,4 enter
        key(4'd1, 1); key(4'd2, 2); key(4'd3, 3); key(4'd4, 4);
        push_pkt(16'h1234);
        key(4'hB, 4);
        chk("send_pin_out", 32'(pin_out), 32'h11234);
        chk("send_busy", 32'(busy), 32'd1);
        idle(1);
        chk("after_send_pin_out", 32'(pin_out), 32'h0FFFF);
        chk("after_send_busy", 32'(busy), 32'd0);
        chk("after_send_count", 32'(digit_count), 32'd0);

        // 7,8,bksp,9,0,5 enter
        key(4'd7, 1); key(4'd8, 2); key(4'hA, 1); key(4'd9, 2); key(4'd0, 3); key(4'd5, 4);
        push_pkt(16'h7905);
        key(4'hB, 4);
        idle(1);

        // overflow digits dropped
        key(4'd1, 1); key(4'd2, 2); key(4'd3, 3); key(4'd4, 4); key(4'd5, 4); key(4'd6, 4);
        push_pkt(16'h1234);
        key(4'hB, 4);
        idle(1);

        // short enter -> error; empty enter -> nothing
        key(4'd3, 1); key(4'd3, 2);
        push_ev(EV_ERR);
        key(4'hB, 0);
        chk("err_pin_out", 32'(pin_out), 32'h0FFFF);
        idle(1);
        chk("err_one_cycle", 32'(err_pulse), 32'd0);
        key(4'hB, 0);
        key(4'hA, 0);
        key(4'd1, 1); key(4'd2, 2); key(4'hD, 2); key(4'hC, 0);
        idle(2);

        // inactivity timeout
        key(4'd9, 1);
        idle(TO - 1);
        chk("pre_expiry_tmo", 32'(timeout_pulse), 32'd0);
        chk("pre_expiry_count", 32'(digit_count), 32'd1);
        push_ev(EV_TMO);
        idle(1);
        chk("expiry_count", 32'(digit_count), 32'd0);
        idle(1);
        chk("tmo_one_cycle", 32'(timeout_pulse), 32'd0);

        // digit on the expiry cycle wins
        key(4'd9, 1);
        idle(TO - 2);
        key(4'd5, 2);
        chk("key_wins_tmo", 32'(timeout_pulse), 32'd0);
        key(4'hC, 0);
        idle(2);

        // reset mid-entry
        key(4'd1, 1); key(4'd2, 2); key(4'd3, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(digit_count), 32'd0);
        chk("midrst_pin_out", 32'(pin_out), 32'h0FFFF);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        key(4'hB, 0);
        key(4'd5, 1); key(4'd6, 2); key(4'd7, 3); key(4'd8, 4);
        push_pkt(16'h5678);
        key(4'hB, 4);
        idle(1);

        // enable dropped mid-entry
        key(4'd1, 1); key(4'd2, 2);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("disable_count", 32'(digit_count), 32'd0);
        key(4'd5, 0);
        enable = 1'b1;
        key(4'hB, 0);

        // digit strobed during SEND is dropped
        key(4'd4, 1); key(4'd3, 2); key(4'd2, 3); key(4'd1, 4);
        push_pkt(16'h4321);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hB;
        @(negedge clk);
        key_code  = 4'd7;
        chk("send_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        key_valid = 1'b0;
        chk("send_drop_count", 32'(digit_count), 32'd0);
        key(4'd8, 1);
        key(4'hC, 0);
        idle(3);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
